// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage initiator: pipeline load/store to req/ack data-memory port
// Lane steering, byte enables, load extension, alignment and timeout faults.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [1:0]        size,
  input  logic              signExt,
  input  logic [ADDR_W-1:0] aluRes,
  input  logic [31:0]       readData2Reg,
  output logic              stall,
  output logic [31:0]       readData,
  output logic              misaligned,
  output logic              busErr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state, next_state;
  logic [7:0]  cnt;
  logic        active, align_ok;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Load formatting context, captured at request time so the pipeline inputs
  // need not be trusted while waiting for the responder.
  logic        rd_q;
  logic [1:0]  off_q;
  logic [1:0]  size_q;
  logic        sext_q;

  assign active = memRead | memWrite;

  always_comb begin
    align_ok = 1'b1;
    be_c     = 4'b1111;
    wdata_c  = readData2Reg;
    case (size)
      2'b00: begin
        be_c    = 4'b0001 << aluRes[1:0];
        wdata_c = {4{readData2Reg[7:0]}};
      end
      2'b01: begin
        align_ok = ~aluRes[0];
        be_c     = aluRes[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{readData2Reg[15:0]}};
      end
      default: begin
        align_ok = (aluRes[1:0] == 2'b00);
      end
    endcase
  end

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] sz, input logic sx);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*off +: 8];
    h = w[16*off[1] +: 16];
    case (sz)
      2'b00:   fmt_load = {{24{sx & b[7]}}, b};
      2'b01:   fmt_load = {{16{sx & h[15]}}, h};
      default: fmt_load = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (active) next_state = align_ok ? WAIT : DONE;
      WAIT:    if (mem_ack || cnt == TO_LAST) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = active;
      WAIT:    stall = 1'b1;
      default: stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= 4'b0000;
      mem_wdata  <= 32'h0;
      readData   <= 32'h0;
      misaligned <= 1'b0;
      busErr     <= 1'b0;
      cnt        <= 8'h0;
      rd_q       <= 1'b0;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      sext_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (active) begin
            if (align_ok) begin
              mem_addr  <= aluRes[ADDR_W-1:2];
              mem_we    <= ~memRead;
              mem_be    <= be_c;
              mem_wdata <= wdata_c;
              mem_req   <= 1'b1;
              cnt       <= 8'h0;
              rd_q      <= memRead;
              off_q     <= aluRes[1:0];
              size_q    <= size;
              sext_q    <= signExt;
            end else begin
              misaligned <= 1'b1;
              readData   <= 32'h0;
            end
          end
        end
        WAIT: begin
          cnt <= cnt + 8'h1;
          if (mem_ack) begin
            mem_req  <= 1'b0;
            busErr   <= 1'b0;
            readData <= rd_q ? fmt_load(mem_rdata, off_q, size_q, sext_q) : 32'h0;
          end else if (cnt == TO_LAST) begin
            mem_req  <= 1'b0;
            busErr   <= 1'b1;
            readData <= 32'h0;
          end
        end
        DONE: begin
          misaligned <= 1'b0;
          busErr     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
